div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Sits between the execute stage and the multicycle unsigned divider core.
- Accepts MIPS DIV/DIVU requests and converts signed operands to magnitudes.
- Launches the core, applies sign correction to the quotient and remainder, and delivers LO/HI write-back with a pipeline stall signal.
- Short-circuits divide-by-zero without using the core, and supports flush/cancel of an in-flight divide.

Parameters:
DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero (HI gets dividend rs)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  divide request; sampled only in IDLE
signed_op  in  1  1=DIV, 0=DIVU
rs  in  32  dividend
rt  in  32  divisor
flush  in  1  pipeline flush; cancels pending result
busy  out  1  stall request to pipeline
result_valid  out  1  one-cycle pulse; hi/lo valid, write HI/LO
lo  out  32  quotient
hi  out  32  remainder
div_en  out  1  core start pulse
div_a  out  32  core dividend magnitude
div_b  out  32  core divisor magnitude
div_q  in  32  core quotient
div_r  in  32  core remainder
div_done  in  1  core completion, high one cycle

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE; busy=0 (no start); result_valid=0; lo=0; hi=0; div_en=0; div_a=0; div_b=0; cancel flag=0.
- States:
  - IDLE: start & ~flush accepted.
    - rt==0: go to FIX with q=DIV0_LO, r=rs; core not launched.
    - Else: latch the operand signs: neg_q = signed_op & (rs[31]^rt[31]); neg_r = signed_op & rs[31].
    - Latch magnitudes into div_a/div_b: abs() when signed_op, else raw.
    - Go to ISSUE.
  - ISSUE: div_en=1 for exactly this cycle, then WAIT. div_en must never be high for two consecutive cycles; the core restarts while it is held.
  - WAIT: hold until div_done. On div_done, capture div_q/div_r into internal registers (core outputs are valid only in that cycle), then go to FIX.
  - FIX: lo <= neg_q ? -q : q; hi <= neg_r ? -r : r. Zero-divisor path applies no negation. result_valid <= ~cancel, then IDLE.
- result_valid is registered: high for exactly the one cycle after FIX, during which the controller is already IDLE.
- A new start is accepted in the same cycle that result_valid is high.
- lo/hi hold their value until the next FIX.
- busy (combinational) = (state!=IDLE) | (start & ~flush & state==IDLE). The pipeline stalls from the request cycle through the FIX cycle.
- Latency from start to result_valid:
  - Core path: 4 + core latency. The core's done pulse arrives about 68 cycles after div_en. The controller must not depend on that exact count.
  - rt==0 path: 2 cycles.
- Arithmetic: 32-bit two's complement negation. -2^31 magnitude passes as 32'h8000_0000 unsigned.
  - DIV -2^31 / -1: lo=32'h8000_0000, hi=0 (wraps, no trap).
- Flush:
  - flush in any non-IDLE state sets cancel.
  - The operation still runs to div_done because the core cannot be aborted except by rst.
  - result_valid is suppressed; lo/hi may update.
  - cancel clears on entering IDLE.
  - flush in IDLE with start: start ignored.
- start while not IDLE: ignored (no queueing).
- Mid-operation rst: returns to IDLE next cycle with all outputs at reset values. The core shares rst, so no stale div_done can arrive.
- A div_done received in any state other than WAIT is ignored.

Test Plan:
1. DIVU rs=100, rt=7 -> div_en single pulse, div_a=100, div_b=7; result_valid one cycle, lo=14, hi=2; busy high from start through FIX.
2. DIV rs=-7 (32'hFFFF_FFF9), rt=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); rt=-2 -> lo=3, hi=-1; rs=7, rt=-2 -> lo=-3, hi=1.
3. DIV rs=32'h8000_0000, rt=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0. DIVU same operands -> lo=0, hi=32'h8000_0000.
4. rt=0, rs=1234 -> div_en never asserted, result_valid 2 cycles after start, lo=32'hFFFF_FFFF, hi=1234.
5. Start DIVU 50/5, assert flush 10 cycles later -> no result_valid; busy stays high until FIX. A following start 9/4 gives lo=2, hi=1 with no stale result.
6. Assert rst during WAIT -> all outputs 0 next cycle. Second start while busy -> ignored, only one div_en pulse. Back-to-back start on the result_valid cycle -> accepted.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Interface bundling the pipeline-side request/result signals and the
// divider-core handshake for div_ctrl.
//   Pipeline side : start, signed_op, rs, rt, flush -> busy, result_valid, lo, hi
//   Core side     : div_en, div_a, div_b -> div_q, div_r, div_done
// slave  : the controller (div_ctrl)
// master : the environment driving requests and modelling the core
interface div_ctrl_if;
  logic        start;
  logic        signed_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic        busy;
  logic        result_valid;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        div_en;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_done;

  modport slave (
    input  start, signed_op, rs, rt, flush, div_q, div_r, div_done,
    output busy, result_valid, lo, hi, div_en, div_a, div_b
  );

  modport master (
    output start, signed_op, rs, rt, flush, div_q, div_r, div_done,
    input  busy, result_valid, lo, hi, div_en, div_a, div_b
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: MIPS DIV/DIVU controller in front of a multicycle unsigned
// divider core. Converts signed operands to magnitudes, launches the core,
// sign-corrects quotient/remainder and returns LO/HI with a stall signal.
// Divide-by-zero bypasses the core. Flush cancels the pending result.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset
//   bus      : div_ctrl_if.slave (request, result, stall and core handshake)
module div_ctrl #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  div_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIX} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        neg_q, neg_r, cancel;
  logic [31:0] q_r, r_r;
  logic [31:0] lo_r, hi_r, a_r, b_r;
  logic        rv_r;
  logic        busy_c, en_c;

  assign accept = (state == IDLE) & bus.start & ~bus.flush;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.rt == 32'd0) ? FIX : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.div_done) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: the core launch is a single-cycle strobe tied to ISSUE so it
  // can never be held across two cycles
  always_comb begin
    busy_c = (state != IDLE) | accept;
    en_c   = (state == ISSUE);
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_r   <= '0;
      hi_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      q_r    <= '0;
      r_r    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cancel <= 1'b0;
      rv_r   <= 1'b0;
    end else begin
      rv_r <= 1'b0;
      if (state != IDLE && bus.flush) cancel <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          if (bus.rt == 32'd0) begin
            // zero divisor: result is fixed, no sign correction
            q_r   <= DIV0_LO;
            r_r   <= bus.rs;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else begin
            neg_q <= bus.signed_op & (bus.rs[31] ^ bus.rt[31]);
            neg_r <= bus.signed_op & bus.rs[31];
            // -2^31 negates to itself, which is the correct unsigned magnitude
            a_r   <= (bus.signed_op & bus.rs[31]) ? -bus.rs : bus.rs;
            b_r   <= (bus.signed_op & bus.rt[31]) ? -bus.rt : bus.rt;
          end
        end
        // core outputs are only valid in the done cycle
        WAIT: if (bus.div_done) begin
          q_r <= bus.div_q;
          r_r <= bus.div_r;
        end
        FIX: begin
          lo_r   <= neg_q ? -q_r : q_r;
          hi_r   <= neg_r ? -r_r : r_r;
          // a flush landing in FIX itself also suppresses the write-back
          rv_r   <= ~(cancel | bus.flush);
          cancel <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy_c;
  assign bus.div_en       = en_c;
  assign bus.result_valid = rv_r;
  assign bus.lo           = lo_r;
  assign bus.hi           = hi_r;
  assign bus.div_a        = a_r;
  assign bus.div_b        = b_r;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst;
  div_ctrl_if bus();

  div_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int tests = 0, errors = 0;
  int rv_cnt = 0, en_cnt = 0, en_dbl = 0, exp_rv = 0;
  int core_lat = 68;
  logic en_prev = 1'b0;
  logic inj = 1'b0;

  // behavioural divider core: done pulse core_lat cycles after div_en,
  // outputs are garbage outside the done cycle
  logic [31:0] ca, cb;
  int cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
      bus.div_done <= 1'b0;
      en_prev <= 1'b0;
    end else begin
      bus.div_done <= 1'b0;
      bus.div_q <= $urandom;
      bus.div_r <= $urandom;
      en_prev <= bus.div_en;
      if (bus.div_en && en_prev) en_dbl <= en_dbl + 1;
      if (bus.div_en) begin
        en_cnt <= en_cnt + 1;
        ca <= bus.div_a;
        cb <= bus.div_b;
        cnt <= core_lat;
      end else if (cnt == 1) begin
        bus.div_done <= 1'b1;
        bus.div_q <= (cb == 0) ? 32'hDEAD_BEEF : ca / cb;
        bus.div_r <= (cb == 0) ? 32'hDEAD_BEEF : ca % cb;
        cnt <= 0;
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end else if (inj) begin
        bus.div_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (bus.result_valid) rv_cnt <= rv_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: MIPS semantics via 64-bit arithmetic (truncating division)
  task automatic model(input bit so, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo_o, output logic [31:0] hi_o);
    longint sa, sb, q, r;
    if (b == 0) begin
      lo_o = 32'hFFFF_FFFF;
      hi_o = a;
    end else begin
      if (so) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      lo_o = q[31:0];
      hi_o = r[31:0];
    end
  endtask

  // issues a request at the current time (caller is at a negedge) and
  // returns at the negedge where result_valid is high
  task automatic run_op(input bit so, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] lo_o, output logic [31:0] hi_o, output int lat);
    int cyc;
    bit busy_ok;
    bus.start = 1'b1; bus.signed_op = so; bus.rs = a; bus.rt = b;
    #1 chk("busy_req", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!bus.result_valid && cyc < 400) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("rv_seen", 32'(bus.result_valid), 32'd1);
    chk("busy_thru_fix", 32'(busy_ok), 32'd1);
    chk("busy_rv_cycle", 32'(bus.busy), 32'd0);
    lo_o = bus.lo;
    hi_o = bus.hi;
    lat = cyc;
    exp_rv++;
  endtask

  typedef struct {
    bit          so;
    logic [31:0] a, b, elo, ehi;
    bit          chk_ab;
    logic [31:0] ea, eb;
  } vec_t;

  vec_t vec[8];

  initial begin
    logic [31:0] lo_v, hi_v, elo, ehi, a, b, lo_hold;
    int lat, en0, rv0, cyc;
    bit so;

    vec[0] = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 1, 32'd100, 32'd7};
    vec[1] = '{1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, 32'd7, 32'd2};
    vec[2] = '{1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1, 32'd7, 32'd2};
    vec[3] = '{1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1, 32'd7, 32'd2};
    vec[4] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1, 32'h8000_0000, 32'd1};
    vec[5] = '{0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1, 32'h8000_0000, 32'hFFFF_FFFF};
    vec[6] = '{0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 0, 32'd0, 32'd0};
    vec[7] = '{1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 0, 32'd0, 32'd0};

    rst = 1'b1;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.rs = '0; bus.rt = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rv", 32'(bus.result_valid), 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_en", 32'(bus.div_en), 32'd0);
    chk("rst_a", bus.div_a, 32'd0);
    chk("rst_b", bus.div_b, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 8; i++) begin
      en0 = en_cnt;
      run_op(vec[i].so, vec[i].a, vec[i].b, lo_v, hi_v, lat);
      chk($sformatf("vec%0d_lo", i), lo_v, vec[i].elo);
      chk($sformatf("vec%0d_hi", i), hi_v, vec[i].ehi);
      if (vec[i].b == 0) begin
        chk($sformatf("vec%0d_div0_lat", i), 32'(lat), 32'd2);
        chk($sformatf("vec%0d_div0_noen", i), 32'(en_cnt - en0), 32'd0);
      end else begin
        chk($sformatf("vec%0d_en_once", i), 32'(en_cnt - en0), 32'd1);
        chk($sformatf("vec%0d_lat_min", i), 32'(lat > 68), 32'd1);
      end
      if (vec[i].chk_ab) begin
        chk($sformatf("vec%0d_div_a", i), bus.div_a, vec[i].ea);
        chk($sformatf("vec%0d_div_b", i), bus.div_b, vec[i].eb);
      end
      @(negedge clk);
      chk($sformatf("vec%0d_rv_pulse", i), 32'(bus.result_valid), 32'd0);
    end

    // flush during WAIT
    rv0 = rv_cnt;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.rs = 32'd50; bus.rt = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("flush_busy_held", 32'(cyc > 50), 32'd1);
    chk("flush_idle", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("flush_no_rv", 32'(rv_cnt - rv0), 32'd0);
    run_op(1'b0, 32'd9, 32'd4, lo_v, hi_v, lat);
    chk("post_flush_lo", lo_v, 32'd2);
    chk("post_flush_hi", hi_v, 32'd1);
    @(negedge clk);
    chk("post_flush_rv_once", 32'(rv_cnt - rv0), 32'd1);

    // reset during WAIT
    rv0 = rv_cnt;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.rs = 32'd1000; bus.rt = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_rv", 32'(bus.result_valid), 32'd0);
    chk("mid_rst_lo", bus.lo, 32'd0);
    chk("mid_rst_hi", bus.hi, 32'd0);
    chk("mid_rst_en", 32'(bus.div_en), 32'd0);
    chk("mid_rst_a", bus.div_a, 32'd0);
    chk("mid_rst_b", bus.div_b, 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_rst_no_rv", 32'(rv_cnt - rv0), 32'd0);

    // second start while busy is ignored
    en0 = en_cnt;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.rs = 32'd77; bus.rt = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.rs = 32'd1; bus.rt = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.result_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    exp_rv++;
    chk("ign_start_rv", 32'(bus.result_valid), 32'd1);
    chk("ign_start_lo", bus.lo, 32'd11);
    chk("ign_start_hi", bus.hi, 32'd0);
    chk("ign_start_en_once", 32'(en_cnt - en0), 32'd1);
    @(negedge clk);

    // start together with flush in IDLE is ignored
    en0 = en_cnt;
    bus.start = 1'b1; bus.flush = 1'b1; bus.rs = 32'd5; bus.rt = 32'd1;
    #1 chk("flush_start_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_start_noen", 32'(en_cnt - en0), 32'd0);
    chk("flush_start_idle", 32'(bus.busy), 32'd0);

    // stray done while IDLE is ignored
    rv0 = rv_cnt;
    lo_hold = bus.lo;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_done_rv", 32'(rv_cnt - rv0), 32'd0);
    chk("stray_done_lo", bus.lo, lo_hold);

    // randomized, back-to-back (each start lands on the previous result cycle)
    for (int i = 0; i < 40; i++) begin
      so = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 16);
        3: b = -$urandom_range(1, 16);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      core_lat = $urandom_range(1, 12);
      model(so, a, b, elo, ehi);
      run_op(so, a, b, lo_v, hi_v, lat);
      chk($sformatf("rnd%0d_lo(%0d %h/%h)", i, so, a, b), lo_v, elo);
      chk($sformatf("rnd%0d_hi(%0d %h/%h)", i, so, a, b), hi_v, ehi);
    end
    @(negedge clk);
    @(negedge clk);

    chk("rv_total", 32'(rv_cnt), 32'(exp_rv));
    chk("en_never_double", 32'(en_dbl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
